lcd_text_writer: RTL and testbench

Character-stream front end for the LCD controller. It buffers ASCII codes from the keyboard decoder and tracks the cursor on a 2-row display. It turns each code into one or more 9-bit LCD words (RS plus data), handling line wrap, Enter and Backspace. It paces delivery against the LCD controller's busy flag and sits directly upstream of that controller, driving its data-in and data-ready inputs.

---
 rtl/lcd_text_writer_if.sv | 23 ++
 rtl/lcd_text_writer.sv | 176 +++++++++++++++++
 tb/tb_lcd_text_writer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_writer_if.sv
// rtl/lcd_text_writer_if.sv - keyboard-side and LCD-side signals of the text writer
interface lcd_text_writer_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       lcd_busy;
  logic [8:0] lcd_data;
  logic       lcd_data_ready;
  logic       cursor_row;
  logic [4:0] cursor_col;
  logic       overflow;

  // The text writer itself
  modport slave (
    input  char_in, char_valid, lcd_busy,
    output lcd_data, lcd_data_ready, cursor_row, cursor_col, overflow
  );

  // Keyboard decoder plus LCD controller, seen from the writer's neighbours
  modport master (
    output char_in, char_valid, lcd_busy,
    input  lcd_data, lcd_data_ready, cursor_row, cursor_col, overflow
  );
endinterface

// File: rtl/lcd_text_writer.sv
// rtl/lcd_text_writer.sv - buffers ASCII codes and sequences 9-bit LCD words with cursor tracking
module lcd_text_writer #(
  parameter int COLS       = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clock,
  input  logic               internal_reset,
  lcd_text_writer_if.slave   bus
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     L_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [5:0]      L_COLS  = 6'(COLS);

  typedef enum logic [2:0] {
    S_INIT_HI, S_INIT_LO, S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO
  } state_t;

  state_t          r_state;
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic [8:0]      r_w0, r_w1, r_w2;
  logic [1:0]      r_nwords, r_idx;
  logic [8:0]      r_lcd_data;
  logic            r_ready;
  logic            r_row;
  logic [4:0]      r_col;

  logic            w_full, w_push, w_pop;
  logic [7:0]      w_code;
  logic [5:0]      w_col_inc;
  logic [1:0]      w_n;
  logic [8:0]      w_w0, w_w1, w_w2, w_cur;
  logic            w_nrow;
  logic [4:0]      w_ncol;
  logic [7:0]      w_addr;

  // Fullness uses the count before this edge, so a same-edge pop never frees a slot
  assign w_full = (r_count == L_DEPTH);
  assign w_push = bus.char_valid && !w_full;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_code = r_fifo[r_rd_ptr];

  assign bus.lcd_data       = r_lcd_data;
  assign bus.lcd_data_ready = r_ready;
  assign bus.cursor_row     = r_row;
  assign bus.cursor_col     = r_col;
  assign bus.overflow       = r_overflow;

  // Character storage; contents need no reset since pointers define validity
  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.char_in;
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (bus.char_valid && w_full) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Translate the head code into up to three LCD words and the resulting cursor
  always_comb begin
    w_n       = 2'd0;
    w_w0      = 9'h000;
    w_w1      = 9'h000;
    w_w2      = 9'h000;
    w_nrow    = r_row;
    w_ncol    = r_col;
    w_col_inc = {1'b0, r_col} + 6'd1;
    w_addr    = 8'h00;
    if (w_code >= 8'h20 && w_code <= 8'h7E) begin
      w_w0 = {1'b1, w_code};
      if (w_col_inc == L_COLS) begin
        // Row 0 wraps to row 1; row 1 wraps by clearing the screen
        w_n    = 2'd2;
        w_w1   = r_row ? 9'h001 : 9'h0C0;
        w_nrow = ~r_row;
        w_ncol = 5'd0;
      end else begin
        w_n    = 2'd1;
        w_ncol = w_col_inc[4:0];
      end
    end else if (w_code == 8'h0D) begin
      w_n    = 2'd1;
      w_w0   = r_row ? 9'h001 : 9'h0C0;
      w_nrow = ~r_row;
      w_ncol = 5'd0;
    end else if (w_code == 8'h08 && r_col != 5'd0) begin
      // Move back, blank the cell, then park the cursor on it again
      w_ncol = r_col - 5'd1;
      w_addr = {1'b1, r_row, 1'b0, w_ncol};
      w_n    = 2'd3;
      w_w0   = {1'b0, w_addr};
      w_w1   = 9'h120;
      w_w2   = {1'b0, w_addr};
    end
  end

  // Select the pending word for the current list position
  always_comb begin
    case (r_idx)
      2'd0:    w_cur = r_w0;
      2'd1:    w_cur = r_w1;
      default: w_cur = r_w2;
    endcase
  end

  // Sequencer: init handshake, pop/decode, and busy-paced word delivery
  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) begin
      r_state    <= S_INIT_HI;
      r_w0       <= 9'h000;
      r_w1       <= 9'h000;
      r_w2       <= 9'h000;
      r_nwords   <= 2'd0;
      r_idx      <= 2'd0;
      r_lcd_data <= 9'h000;
      r_ready    <= 1'b0;
      r_row      <= 1'b0;
      r_col      <= 5'd0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_INIT_HI: if (bus.lcd_busy)  r_state <= S_INIT_LO;
        S_INIT_LO: if (!bus.lcd_busy) r_state <= S_IDLE;
        S_IDLE: begin
          if (w_pop) begin
            r_row    <= w_nrow;
            r_col    <= w_ncol;
            r_w0     <= w_w0;
            r_w1     <= w_w1;
            r_w2     <= w_w2;
            r_nwords <= w_n;
            r_idx    <= 2'd0;
            if (w_n != 2'd0) r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!bus.lcd_busy) begin
            r_lcd_data <= w_cur;
            r_ready    <= 1'b1;
            r_state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: if (bus.lcd_busy) r_state <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (!bus.lcd_busy) begin
            if (r_idx + 2'd1 < r_nwords) begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_SEND;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_INIT_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// tb/tb_lcd_text_writer.sv - directed vector bench for lcd_text_writer
module tb_lcd_text_writer;

  logic clock;
  logic internal_reset;
  logic model_en;
  logic man_busy;
  logic m_busy;
  int   dly;
  int   hi;
  int   cyc;
  int   last_act;
  int   n_cmp;
  int   n_err;
  logic [8:0] words [$];

  lcd_text_writer_if ifc ();

  lcd_text_writer #(.COLS(16), .FIFO_DEPTH(8)) dut (
    .clock          (clock),
    .internal_reset (internal_reset),
    .bus            (ifc)
  );

  assign ifc.lcd_busy = model_en ? m_busy : man_busy;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  // LCD controller model: busy rises 2 cycles after a strobe and stays high 10 cycles
  always @(negedge clock) begin
    if (!model_en) begin
      m_busy = 1'b0;
      dly    = 0;
      hi     = 0;
    end else if (ifc.lcd_data_ready) begin
      dly = 2;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        m_busy = 1'b1;
        hi     = 10;
      end
    end else if (m_busy) begin
      hi--;
      if (hi == 0) m_busy = 1'b0;
    end
  end

  // Capture every strobed word
  always @(negedge clock) begin
    if (ifc.lcd_data_ready) begin
      words.push_back(ifc.lcd_data);
      last_act = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] c);
    @(negedge clock);
    ifc.char_in    = c;
    ifc.char_valid = 1'b1;
    @(negedge clock);
    ifc.char_valid = 1'b0;
    last_act = cyc;
  endtask

  task automatic wait_quiet(input int budget);
    int start;
    start = cyc;
    forever begin
      @(negedge clock);
      if (cyc - last_act > 40 && !m_busy && dly == 0) break;
      if (cyc - start > budget) begin
        n_cmp++;
        n_err++;
        $display("FAIL quiet_timeout: still active after %0d cycles", budget);
        break;
      end
    end
  endtask

  task automatic do_reset_init();
    model_en       = 1'b0;
    man_busy       = 1'b0;
    internal_reset = 1'b1;
    ifc.char_valid = 1'b0;
    ifc.char_in    = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_lcd_data", int'(ifc.lcd_data), 'h000);
    check("rst_ready",    int'(ifc.lcd_data_ready), 0);
    check("rst_row",      int'(ifc.cursor_row), 0);
    check("rst_col",      int'(ifc.cursor_col), 0);
    check("rst_overflow", int'(ifc.overflow), 0);
    internal_reset = 1'b0;
    repeat (2) @(negedge clock);
    man_busy = 1'b1;
    repeat (3) @(negedge clock);
    man_busy = 1'b0;
    repeat (3) @(negedge clock);
    words.delete();
  endtask

  typedef struct {
    int         pre;
    logic [7:0] code;
    int         nexp;
    logic [8:0] e0, e1, e2;
    logic       erow;
    logic [4:0] ecol;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [8:0] exp_q [$];
    n_cmp = 0; n_err = 0; cyc = 0; last_act = 0;
    model_en = 1'b0; man_busy = 1'b0; internal_reset = 1'b1;
    ifc.char_in = 8'h00; ifc.char_valid = 1'b0;

    vecs[0]  = '{0,  8'h41, 1, 9'h141, 9'h000, 9'h000, 1'b0, 5'd1};
    vecs[1]  = '{0,  8'h7E, 1, 9'h17E, 9'h000, 9'h000, 1'b0, 5'd1};
    vecs[2]  = '{0,  8'h20, 1, 9'h120, 9'h000, 9'h000, 1'b0, 5'd1};
    vecs[3]  = '{0,  8'h0D, 1, 9'h0C0, 9'h000, 9'h000, 1'b1, 5'd0};
    vecs[4]  = '{0,  8'h08, 0, 9'h000, 9'h000, 9'h000, 1'b0, 5'd0};
    vecs[5]  = '{0,  8'h1B, 0, 9'h000, 9'h000, 9'h000, 1'b0, 5'd0};
    vecs[6]  = '{0,  8'h7F, 0, 9'h000, 9'h000, 9'h000, 1'b0, 5'd0};
    vecs[7]  = '{0,  8'h1F, 0, 9'h000, 9'h000, 9'h000, 1'b0, 5'd0};
    vecs[8]  = '{2,  8'h08, 3, 9'h081, 9'h120, 9'h081, 1'b0, 5'd1};
    vecs[9]  = '{15, 8'h41, 2, 9'h141, 9'h0C0, 9'h000, 1'b1, 5'd0};
    vecs[10] = '{16, 8'h0D, 1, 9'h001, 9'h000, 9'h000, 1'b0, 5'd0};
    vecs[11] = '{17, 8'h08, 3, 9'h0C0, 9'h120, 9'h0C0, 1'b1, 5'd0};
    vecs[12] = '{16, 8'h08, 0, 9'h000, 9'h000, 9'h000, 1'b1, 5'd0};
    vecs[13] = '{31, 8'h41, 2, 9'h141, 9'h001, 9'h000, 1'b0, 5'd0};
    vecs[14] = '{32, 8'h0D, 1, 9'h0C0, 9'h000, 9'h000, 1'b1, 5'd0};

    for (int v = 0; v < 15; v++) begin
      do_reset_init();
      model_en = 1'b1;
      for (int k = 0; k < vecs[v].pre; k++) begin
        push(8'h41);
        repeat (20) @(negedge clock);
      end
      push(vecs[v].code);
      wait_quiet(3000);
      exp_q.delete();
      for (int k = 1; k <= vecs[v].pre; k++) begin
        exp_q.push_back(9'h141);
        if (k == 16) exp_q.push_back(9'h0C0);
        if (k == 32) exp_q.push_back(9'h001);
      end
      if (vecs[v].nexp > 0) exp_q.push_back(vecs[v].e0);
      if (vecs[v].nexp > 1) exp_q.push_back(vecs[v].e1);
      if (vecs[v].nexp > 2) exp_q.push_back(vecs[v].e2);
      check($sformatf("v%0d_count", v), words.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("v%0d_word%0d", v, i),
              (i < words.size()) ? int'(words[i]) : -1, int'(exp_q[i]));
      check($sformatf("v%0d_row", v), int'(ifc.cursor_row), int'(vecs[v].erow));
      check($sformatf("v%0d_col", v), int'(ifc.cursor_col), int'(vecs[v].ecol));
      check($sformatf("v%0d_ovf", v), int'(ifc.overflow), 0);
    end

    // Init gating: strobe is held off until the controller's busy cycle ends
    model_en = 1'b0; man_busy = 1'b0; internal_reset = 1'b1;
    repeat (2) @(negedge clock);
    internal_reset = 1'b0;
    words.delete();
    repeat (5) @(negedge clock);
    man_busy = 1'b1;
    repeat (10) @(negedge clock);
    push(8'h41);
    repeat (88) @(negedge clock);
    check("init_no_strobe", words.size(), 0);
    man_busy = 1'b0;
    repeat (10) @(negedge clock);
    check("init_count", words.size(), 1);
    check("init_word", (words.size() > 0) ? int'(words[0]) : -1, 'h141);

    // Latency: sample at E, pop at E+1, strobe at E+2 for one cycle
    do_reset_init();
    @(negedge clock);
    ifc.char_in = 8'h43;
    ifc.char_valid = 1'b1;
    @(negedge clock);
    ifc.char_valid = 1'b0;
    check("lat_e0", int'(ifc.lcd_data_ready), 0);
    @(negedge clock);
    check("lat_e1", int'(ifc.lcd_data_ready), 0);
    @(negedge clock);
    check("lat_e2", int'(ifc.lcd_data_ready), 1);
    check("lat_data", int'(ifc.lcd_data), 'h143);
    @(negedge clock);
    check("lat_pulse", int'(ifc.lcd_data_ready), 0);
    check("lat_col", int'(ifc.cursor_col), 1);

    // Async reset while waiting for busy to rise
    #2;
    internal_reset = 1'b1;
    #1;
    check("arst_data", int'(ifc.lcd_data), 'h000);
    check("arst_col", int'(ifc.cursor_col), 0);
    check("arst_ready", int'(ifc.lcd_data_ready), 0);
    @(negedge clock);
    internal_reset = 1'b0;
    words.delete();
    push(8'h42);
    repeat (30) @(negedge clock);
    check("arst_no_strobe", words.size(), 0);
    man_busy = 1'b1;
    repeat (3) @(negedge clock);
    man_busy = 1'b0;
    repeat (10) @(negedge clock);
    check("arst_count", words.size(), 1);
    check("arst_word", (words.size() > 0) ? int'(words[0]) : -1, 'h142);

    // Overflow: one code popped into SEND, eight buffered, tenth dropped
    do_reset_init();
    man_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      ifc.char_in = 8'h30 + 8'(i);
      ifc.char_valid = 1'b1;
    end
    @(negedge clock);
    ifc.char_valid = 1'b0;
    last_act = cyc;
    check("ovf_set", int'(ifc.overflow), 1);
    check("ovf_no_strobe", words.size(), 0);
    model_en = 1'b1;
    wait_quiet(3000);
    check("ovf_count", words.size(), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("ovf_word%0d", i),
            (i < words.size()) ? int'(words[i]) : -1, 'h130 + i);
    check("ovf_sticky", int'(ifc.overflow), 1);
    check("ovf_col", int'(ifc.cursor_col), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
